// File: rtl/uart_tx.sv
// UART transmitter: 8-bit frames (start, D0..D7, optional parity, one stop)
// with a one-byte holding register so the host can queue the next byte.
module uart_tx #(
  parameter int CLKS_PER_BIT = 12,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       Txd,
  output logic       busy,
  output logic       full,
  output logic       tdc
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic          HAS_PAR = (PARITY_EN != 0);
  localparam logic          ODD_PAR = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          par_q, par_d;
  logic          full_q, full_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          tdc_q, tdc_d;
  logic          wr_ok_s;
  logic          bit_end_s;

  function automatic logic parity_of(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      hold_q  <= 8'h00;
      par_q   <= 1'b0;
      full_q  <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      tdc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      par_q   <= par_d;
      full_q  <= full_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      tdc_q   <= tdc_d;
    end
  end

  // Next-state logic; a write is judged against the registered full flag,
  // so a write on the drain edge is refused.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    par_d     = par_q;
    full_d    = full_q;
    wr_ok_s   = wr && ce && !full_q;
    bit_end_s = (cnt_q == CNT_MAX);
    if (wr_ok_s) begin
      hold_d = data;
      full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
    case (state_q)
      IDLE: begin
        if (full_q) begin
          state_d = START;
          shift_d = hold_q;
          par_d   = parity_of(hold_q, ODD_PAR);
          full_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (full_q) begin
            state_d = START;
            shift_d = hold_q;
            par_d   = parity_of(hold_q, ODD_PAR);
            full_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != IDLE);
    tdc_d  = (state_d == STOP) && (cnt_d == CNT_MAX);
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  assign Txd  = txd_q;
  assign busy = busy_q;
  assign full = full_q;
  assign tdc  = tdc_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (no parity, even, odd),
// a serial-line monitor per instance, and directed timing checks.
module tb_uart_tx;

  localparam int CPB = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce_s   [3];
  logic       wr_s   [3];
  logic [7:0] data_s [3];
  logic       txd_s  [3];
  logic       busy_s [3];
  logic       full_s [3];
  logic       tdc_s  [3];

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int rst_epoch = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  always @(negedge rst_n) rst_epoch++;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .rst(rst_n), .ce(ce_s[0]), .wr(wr_s[0]), .data(data_s[0]),
    .Txd(txd_s[0]), .busy(busy_s[0]), .full(full_s[0]), .tdc(tdc_s[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_ev (
    .clk(clk), .rst(rst_n), .ce(ce_s[1]), .wr(wr_s[1]), .data(data_s[1]),
    .Txd(txd_s[1]), .busy(busy_s[1]), .full(full_s[1]), .tdc(tdc_s[1]));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_od (
    .clk(clk), .rst(rst_n), .ce(ce_s[2]), .wr(wr_s[2]), .data(data_s[2]),
    .Txd(txd_s[2]), .busy(busy_s[2]), .full(full_s[2]), .tdc(tdc_s[2]));

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [8:0] v);
    case (idx)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // got = {start, stop, parity, data}
  task automatic check_frame(input int idx, input logic [10:0] got);
    logic [8:0] e;
    vec_cnt++;
    if (q_size(idx) == 0) begin
      err_cnt++;
      $display("FAIL frame_dut%0d: got frame %h, expected no frame", idx, got);
      return;
    end
    case (idx)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (got !== {1'b0, 1'b1, e}) begin
      err_cnt++;
      $display("FAIL frame_dut%0d: got {start,stop,par,data}=%h, expected %h",
               idx, got, {1'b0, 1'b1, e});
    end
  endtask

  // Decodes frames off the line at mid-bit; frames cut by reset are discarded.
  task automatic monitor(input int idx);
    int         ep;
    logic [7:0] d;
    logic       p, st, s0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd_s[idx] === 1'b0) begin
        ep = rst_epoch;
        repeat (CPB / 2) @(negedge clk);
        s0 = txd_s[idx];
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          d[k] = txd_s[idx];
        end
        p = 1'b0;
        if (idx > 0) begin
          repeat (CPB) @(negedge clk);
          p = txd_s[idx];
        end
        repeat (CPB) @(negedge clk);
        st = txd_s[idx];
        if (ep == rst_epoch && rst_n === 1'b1) check_frame(idx, {s0, st, p, d});
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic wr_byte(input int idx, input logic [7:0] b);
    @(negedge clk);
    ce_s[idx]   = 1'b1;
    wr_s[idx]   = 1'b1;
    data_s[idx] = b;
    @(posedge clk);
    #1;
    wr_s[idx] = 1'b0;
  endtask

  // Index 0 is the first negedge after the accepting edge.
  task automatic measure(input int idx, input int maxc, output int busy_cnt,
                         output int tdc_cnt, output int tdc1, output int tdc2,
                         output int full_last, output int drop_i);
    bit seen;
    seen = 1'b0; busy_cnt = 0; tdc_cnt = 0; tdc1 = -1; tdc2 = -1;
    full_last = -1; drop_i = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (busy_s[idx]) begin busy_cnt++; seen = 1'b1; end
      if (tdc_s[idx]) begin
        tdc_cnt++;
        if (tdc1 < 0) tdc1 = i; else tdc2 = i;
      end
      if (full_s[idx]) full_last = i;
      if (seen && !busy_s[idx]) begin drop_i = i; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int bc, tc, t1, t2, fl, dr, act;
    for (int i = 0; i < 3; i++) begin
      ce_s[i] = 1'b0; wr_s[i] = 1'b0; data_s[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_txd%0d", i),  txd_s[i],  1);
      chk($sformatf("rst_busy%0d", i), busy_s[i], 0);
      chk($sformatf("rst_full%0d", i), full_s[i], 0);
      chk($sformatf("rst_tdc%0d", i),  tdc_s[i],  0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5
    push_exp(0, {1'b0, 8'hA5});
    wr_byte(0, 8'hA5);
    measure(0, 400, bc, tc, t1, t2, fl, dr);
    chk("t1_busy_cycles", bc, 120);
    chk("t1_tdc_count", tc, 1);
    chk("t1_tdc_at", t1, 120);
    chk("t1_full_last", fl, 0);
    chk("t1_busy_drop", dr, 121);
    repeat (10) @(negedge clk);

    // Back-to-back 0x55, 0x0F
    push_exp(0, {1'b0, 8'h55});
    push_exp(0, {1'b0, 8'h0F});
    wr_byte(0, 8'h55);
    fork
      measure(0, 600, bc, tc, t1, t2, fl, dr);
      begin repeat (5) @(negedge clk); wr_byte(0, 8'h0F); end
    join
    chk("t2_busy_cycles", bc, 240);
    chk("t2_tdc_count", tc, 2);
    chk("t2_tdc1_at", t1, 120);
    chk("t2_tdc2_at", t2, 240);
    chk("t2_full_last", fl, 120);
    chk("t2_busy_drop", dr, 241);
    repeat (10) @(negedge clk);

    // Overrun: 0x33 is dropped
    push_exp(0, {1'b0, 8'h11});
    push_exp(0, {1'b0, 8'h22});
    wr_byte(0, 8'h11);
    fork
      measure(0, 600, bc, tc, t1, t2, fl, dr);
      begin
        repeat (3) @(negedge clk);
        wr_byte(0, 8'h22);
        wr_byte(0, 8'h33);
      end
    join
    chk("t3_busy_cycles", bc, 240);
    chk("t3_full_last", fl, 120);
    chk("t3_tdc_count", tc, 2);
    repeat (10) @(negedge clk);

    // Parity: 0x07 has three ones, 0x96 has four
    push_exp(1, {1'b1, 8'h07});
    push_exp(1, {1'b0, 8'h96});
    push_exp(2, {1'b0, 8'h07});
    push_exp(2, {1'b1, 8'h96});
    fork
      wr_byte(1, 8'h07);
      wr_byte(2, 8'h07);
    join
    fork
      measure(1, 600, bc, tc, t1, t2, fl, dr);
      begin
        repeat (3) @(negedge clk);
        fork
          wr_byte(1, 8'h96);
          wr_byte(2, 8'h96);
        join
      end
    join
    chk("t4_busy_cycles", bc, 264);
    chk("t4_tdc1_at", t1, 132);
    chk("t4_tdc2_at", t2, 264);
    chk("t4_full_last", fl, 132);
    chk("t4_busy_drop", dr, 265);
    repeat (20) @(negedge clk);

    // Reset during D3 of 0xF0 with 0x99 held
    wr_byte(0, 8'hF0);
    fork
      begin repeat (3) @(negedge clk); wr_byte(0, 8'h99); end
      begin repeat (54) @(negedge clk); end
    join
    chk("t5_pre_txd", txd_s[0], 0);
    chk("t5_pre_full", full_s[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_txd", txd_s[0], 1);
    chk("t5_rst_busy", busy_s[0], 0);
    chk("t5_rst_full", full_s[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!txd_s[0] || busy_s[0] || full_s[0]) act++;
    end
    chk("t5_idle_after_rst", act, 0);

    // ce gating
    @(negedge clk);
    ce_s[0] = 1'b0; wr_s[0] = 1'b1; data_s[0] = 8'h3C;
    act = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (!txd_s[0] || busy_s[0] || full_s[0]) act++;
    end
    wr_s[0] = 1'b0;
    chk("t6_ce0_ignored", act, 0);
    push_exp(0, {1'b0, 8'hC3});
    wr_byte(0, 8'hC3);
    fork
      measure(0, 400, bc, tc, t1, t2, fl, dr);
      begin
        repeat (30) @(negedge clk);
        ce_s[0] = 1'b0; wr_s[0] = 1'b1; data_s[0] = 8'h5A;
      end
    join
    wr_s[0] = 1'b0;
    chk("t6_busy_cycles", bc, 120);
    chk("t6_full_last", fl, 0);
    chk("t6_tdc_at", t1, 120);

    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("queue_empty%0d", i), q_size(i), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter and counterpart to the team's UART receiver. It serialises bytes onto Txd as 8-bit frames: start bit, data LSB first, optional parity, one stop bit.
The block generates its own bit timing from clk and has a one-byte holding register, so the host can queue the next byte while the current frame shifts out.
It sits beside the receiver on the same clock and shares the ce/data-bus style of host interface.

Parameters:
CLKS_PER_BIT, 12, clk cycles per serial bit; legal range 2 to 65535; bit counter width is clog2(CLKS_PER_BIT).
PARITY_EN, 0, 1 inserts a parity bit between D7 and the stop bit.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
ce  input  1  chip enable; writes are accepted only while ce=1.
wr  input  1  write strobe; level-sampled on each clk edge.
data  input  8  byte to transmit; sampled when a write is accepted.
Txd  output  1  serial line; idles high.
busy  output  1  1 while a frame is on the line (start bit through stop bit).
full  output  1  1 while the holding register holds an unsent byte.
tdc  output  1  transmit-done pulse; high for one clk at the end of each stop bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - Txd=1, busy=0, full=0, tdc=0.
  - State returns to IDLE; bit counter, clock counter and shifter clear; any held byte is discarded.
  - Reset mid-frame aborts the frame; Txd goes high immediately, with no clk edge needed.
- Write acceptance: a write is accepted on an edge where wr=1, ce=1 and full=0.
  - data is latched into the holding register; full=1 from the next cycle.
- Write with full=1, or with ce=0, is ignored: byte dropped, no flag, no state change.
- The write condition is evaluated against the registered full value. A write on the same edge as the holding-register drain is therefore refused.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Txd=1, busy=0. If full=1: load shifter from hold, full=0, busy=1, Txd=0, go to START.
  - START: Txd=0 for CLKS_PER_BIT clks, then go to DATA.
  - DATA: Txd=shifter[0] for CLKS_PER_BIT clks per bit. Shift right after each bit. After 8 bits go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: Txd = XOR of the 8 data bits, XORed with PARITY_ODD, held for CLKS_PER_BIT clks.
  - STOP: Txd=1 for CLKS_PER_BIT clks. On the last clk of the stop bit, tdc=1 for that one clk.
    - If full=1 at that point: reload the shifter from hold, full=0, go straight to START. There is no idle gap and busy stays 1.
    - Else: go to IDLE, busy=0.
- Latency:
  - Write accepted at edge n with the block idle: full=1 after edge n; Txd falls after edge n+1.
  - Frame length is exactly (10+PARITY_EN)*CLKS_PER_BIT clks.
  - Back-to-back frames abut exactly.
- ce=0 mid-frame does not stop transmission; the frame and any held byte are still sent.
- Every output is registered; Txd is glitch-free.
- The clock counter wraps at CLKS_PER_BIT-1 to 0. Each bit period is exactly CLKS_PER_BIT clks, with no off-by-one on the first or last bit.

Test Plan:
1. Single byte: CLKS_PER_BIT=12, PARITY_EN=0, write 0xA5 -> Txd = 0,1,0,1,0,0,1,0,1,1, each bit for 12 clks (120 clks total). tdc pulses once on clk 120. busy drops the next cycle.
2. Back-to-back: write 0x55, then write 0x0F while busy -> full=1 until the first stop bit ends. The second start bit begins with no gap; total 240 clks of busy; two tdc pulses 120 clks apart.
3. Overrun: write 0x11, then 0x22 (held), then 0x33 while full=1 -> 0x33 dropped. Only 0x11 and 0x22 appear on Txd.
4. Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, frame 132 clks. With PARITY_ODD=1 -> parity bit 0.
5. Reset mid-frame: assert rst during D3 of 0xF0 with a byte held -> Txd=1, busy=0, full=0 immediately. After release, the line stays idle and the held byte is never sent.
6. ce gating: wr=1 with ce=0 and data 0x3C -> no write accepted, Txd stays 1. Drop ce mid-frame -> the frame completes unchanged.
